// File: rtl/sbus_if.sv
// sbus_if: datapath-side bus between a datapath master port (ibus/dbus) and its
// slave adapter.
//
// Valid/ready semantics on this bus: the master raises `en` with `we`, `size`,
// `addr` and `data_w`, and holds all of them stable while `stall` is high. The
// request is complete in the first cycle in which `en` is high and `stall` is
// low. A read's data is then on `data_r`, and it stays there until the next
// read completes.
//
// Signals:
//   en      master->slave  access request (level held)
//   we      master->slave  1 = write, 0 = read
//   size    master->slave  00 byte, 01 half, 10 word
//   addr    master->slave  byte address
//   data_w  master->slave  write data, lanes already placed
//   data_r  slave->master  registered read data
//   stall   slave->master  hold the current request
interface sbus_if;
    logic        en;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data_w;
    logic [31:0] data_r;
    logic        stall;

    modport master (
        output en, we, size, addr, data_w,
        input  data_r, stall
    );

    modport slave (
        input  en, we, size, addr, data_w,
        output data_r, stall
    );
endinterface

// File: rtl/sbus_sram_bridge.sv
// sbus_sram_bridge: turns a level-held sbus request with `stall` back-pressure
// into a split-transaction SRAM-like request (req/addr_ok/data_ok).
//
// The bridge keeps at most one transaction outstanding. It registers read data
// for the master. It suppresses misaligned accesses, which the datapath raises
// as AdEL/AdES itself.
//
// SRAM side: `req` is qualified by `addr_ok`. While `req` is high and `addr_ok`
// is low, the request fields are held. `data_ok` completes the transaction
// with read data or a write ack, no earlier than the cycle after `addr_ok`.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   sbus       sbus_if.slave (en/we/size/addr/data_w in, data_r/stall out)
//   cancel     flush: drop the current request
//   req        SRAM request valid
//   wr         write request
//   size       copy of sbus.size
//   addr       request address
//   wstrb      byte-lane enables for writes, 4'b0000 on reads
//   wdata      sbus.data_w unchanged
//   addr_ok    request accepted this cycle
//   rdata      read data, valid with data_ok
//   data_ok    transaction complete
//   dbg_state  FSM state: 0 IDLE, 1 WAIT, 2 DONE, 3 DRAIN
//
// Optional feature macro: SBUS_BRIDGE_ADDR_MAP_EN. When it is defined,
// kseg0/kseg1 addresses (addr[31:30]==2'b10) are mapped to physical space by
// clearing the top three bits.
module sbus_sram_bridge #(
    parameter logic [31:0] RESET_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    sbus_if.slave       sbus,
    input  logic        cancel,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic [31:0] rdata,
    input  logic        data_ok,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] data_r_q;
    logic        rd_pending;   // the accepted transaction is a read
    logic        mis;
    logic        go;
    logic [3:0]  strb;

    assign mis = ((sbus.size == 2'b01) && sbus.addr[0]) ||
                 ((sbus.size == 2'b10) && (sbus.addr[1:0] != 2'b00));
    assign go  = sbus.en && !mis && !cancel;

    always_comb begin
        strb = 4'b0000;
        case (sbus.size)
            2'b00:   strb = 4'b0001 << sbus.addr[1:0];
            2'b01:   strb = sbus.addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
    end

    // The request fields are straight copies of the held sbus request. The
    // master keeps them stable while stalled, so they need no registering.
    assign wr    = sbus.we;
    assign size  = sbus.size;
    assign wdata = sbus.data_w;
    assign wstrb = (sbus.en && sbus.we) ? strb : 4'b0000;

`ifdef SBUS_BRIDGE_ADDR_MAP_EN
    assign addr = (sbus.addr[31:30] == 2'b10) ? {3'b000, sbus.addr[28:0]} : sbus.addr;
`else
    assign addr = sbus.addr;
`endif

    // req and stall come from the state combinationally. Gating them with rst
    // makes both drop in the same instant as an asynchronous reset, even while
    // the master still holds en.
    assign req = rst && (state == ST_IDLE) && go;

    always_comb begin
        sbus.stall = 1'b0;
        case (state)
            ST_IDLE:  sbus.stall = go;
            ST_WAIT:  sbus.stall = !cancel;
            ST_DONE:  sbus.stall = 1'b0;
            ST_DRAIN: sbus.stall = sbus.en && !cancel;
            default:  sbus.stall = 1'b0;
        endcase
        if (!rst) sbus.stall = 1'b0;
    end

    assign sbus.data_r = data_r_q;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            data_r_q   <= RESET_DATA;
            rd_pending <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req && addr_ok) begin
                        state      <= ST_WAIT;
                        rd_pending <= !sbus.we;
                    end
                end
                ST_WAIT: begin
                    if (data_ok) begin
                        if (cancel) begin
                            // The flush arrived with the data, so the data
                            // is dropped and the bridge goes straight back.
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_DONE;
                            if (rd_pending) data_r_q <= rdata;
                        end
                    end else if (cancel) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                ST_DRAIN: begin
                    // The slave still owes one data_ok. It has to be absorbed
                    // before a new request may go out.
                    if (data_ok) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sbus_sram_bridge.sv
module tb_sbus_sram_bridge;

    localparam logic [31:0] RST_VAL = 32'hDEAD_BEEF;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sbus_if bus ();

    logic        cancel;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic [31:0] rdata;
    logic        data_ok;
    logic [1:0]  dbg_state;

    sbus_sram_bridge #(.RESET_DATA(RST_VAL)) dut (
        .clk       (clk),
        .rst       (rst),
        .sbus      (bus.slave),
        .cancel    (cancel),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .addr      (addr),
        .wstrb     (wstrb),
        .wdata     (wdata),
        .addr_ok   (addr_ok),
        .rdata     (rdata),
        .data_ok   (data_ok),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_data;   // what the master must see on data_r

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference rules, taken directly from the byte-lane and address tables.
    function automatic logic [3:0] ref_strb(input logic we, input logic [1:0] sz, input logic [31:0] a);
        if (!we) return 4'b0000;
        case (sz)
            2'b00: return (a[1:0] == 2'd0) ? 4'b0001 : (a[1:0] == 2'd1) ? 4'b0010 :
                          (a[1:0] == 2'd2) ? 4'b0100 : 4'b1000;
            2'b01: return a[1] ? 4'b1100 : 4'b0011;
            2'b10: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_addr(input logic [31:0] a);
`ifdef SBUS_BRIDGE_ADDR_MAP_EN
        if (a[31:30] == 2'b10) return a & 32'h1FFF_FFFF;
`endif
        return a;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input string tag);
        bus.en = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; cancel = 1'b0;
        #1;
        chk({tag, "_req"},   {31'b0, req},       32'd0);
        chk({tag, "_stall"}, {31'b0, bus.stall}, 32'd0);
        tick();
    endtask

    // One full transaction. The slave accepts after a_dly cycles and returns
    // data_ok d_dly (>=1) cycles later. en is left high, so the caller may
    // start the next request back to back.
    task automatic do_txn(input string tag, input logic we, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int a_dly, input int d_dly, input logic [31:0] rd_val);
        bus.en = 1'b1; bus.we = we; bus.size = sz; bus.addr = a; bus.data_w = wd;
        cancel = 1'b0; data_ok = 1'b0;
        for (int c = 0; c <= a_dly; c++) begin
            addr_ok = (c == a_dly);
            #1;
            chk({tag, "_req"},   {31'b0, req},       32'd1);
            chk({tag, "_stall"}, {31'b0, bus.stall}, 32'd1);
            chk({tag, "_wr"},    {31'b0, wr},        {31'b0, we});
            chk({tag, "_size"},  {30'b0, size},      {30'b0, sz});
            chk({tag, "_addr"},  addr,               ref_addr(a));
            chk({tag, "_wstrb"}, {28'b0, wstrb},     {28'b0, ref_strb(we, sz, a)});
            chk({tag, "_wdata"}, wdata,              wd);
            tick();
        end
        addr_ok = 1'b0;
        for (int c = 1; c <= d_dly; c++) begin
            data_ok = (c == d_dly);
            rdata   = data_ok ? rd_val : $urandom;
            if (data_ok && !we) exp_q.push_back(rd_val);
            #1;
            chk({tag, "_wait_req"},   {31'b0, req},       32'd0);
            chk({tag, "_wait_stall"}, {31'b0, bus.stall}, 32'd1);
            tick();
        end
        data_ok = 1'b0;
        rdata   = $urandom;
        #1;
        chk({tag, "_done_stall"}, {31'b0, bus.stall}, 32'd0);
        chk({tag, "_done_req"},   {31'b0, req},       32'd0);
        if (!we && exp_q.size() > 0) exp_data = exp_q.pop_front();
        chk({tag, "_data_r"}, bus.data_r, exp_data);
        tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic        we;

        rst = 1'b0; cancel = 1'b0; addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h0;
        bus.en = 1'b0; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0; bus.data_w = 32'h0;
        exp_data = RST_VAL;

        // reset state
        #12;
        chk("rst_req",   {31'b0, req},       32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        chk("rst_wstrb", {28'b0, wstrb},     32'd0);
        chk("rst_data",  bus.data_r,         RST_VAL);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b1;
        tick();

        // best-case word read
        do_txn("rd_best", 1'b0, 2'b10, 32'hBFC0_0000, 32'h0, 0, 1, 32'h1234_5678);
        chk("rd_best_val", bus.data_r, 32'h1234_5678);
        idle_cycle("gap0");

        // byte write with addr_ok delayed by 3 cycles
        do_txn("wr_byte", 1'b1, 2'b00, 32'h0000_1002, 32'h00AB_0000, 3, 2, 32'hFFFF_FFFF);
        idle_cycle("gap1");

        // misaligned half and word: no request, no stall
        bus.en = 1'b1; bus.we = 1'b0; bus.size = 2'b01; bus.addr = 32'h0000_2001;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("mis_h_req",   {31'b0, req},       32'd0);
            chk("mis_h_stall", {31'b0, bus.stall}, 32'd0);
            chk("mis_h_state", {30'b0, dbg_state}, 32'd0);
            chk("mis_h_data",  bus.data_r,         exp_data);
            tick();
        end
        bus.size = 2'b10; bus.addr = 32'h0000_2002; bus.we = 1'b1;
        #1;
        chk("mis_w_req",   {31'b0, req},       32'd0);
        chk("mis_w_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        idle_cycle("gap2");

        // cancel while waiting, data_ok two cycles later; new request waits
        bus.en = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0000_3000;
        addr_ok = 1'b1;
        #1;
        chk("cx_acc_req", {31'b0, req}, 32'd1);
        tick();
        addr_ok = 1'b0; cancel = 1'b1; bus.en = 1'b0;
        #1;
        chk("cx_wait_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        cancel = 1'b0; bus.en = 1'b1; bus.addr = 32'h0000_3100;
        #1;
        chk("cx_drain_state", {30'b0, dbg_state}, 32'd3);
        chk("cx_drain_stall", {31'b0, bus.stall}, 32'd1);
        chk("cx_drain_req",   {31'b0, req},       32'd0);
        tick();
        data_ok = 1'b1; rdata = 32'h5555_AAAA;
        #1;
        chk("cx_drok_stall", {31'b0, bus.stall}, 32'd1);
        chk("cx_drok_req",   {31'b0, req},       32'd0);
        tick();
        data_ok = 1'b0;
        #1;
        chk("cx_after_data", bus.data_r, exp_data);
        do_txn("cx_new", 1'b0, 2'b10, 32'h0000_3100, 32'h0, 1, 2, 32'h0BAD_F00D);
        idle_cycle("gap3");

        // cancel together with data_ok: straight to IDLE, data dropped
        bus.en = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0000_3200;
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0; cancel = 1'b1; data_ok = 1'b1; rdata = 32'h7777_7777; bus.en = 1'b0;
        #1;
        chk("cxd_stall", {31'b0, bus.stall}, 32'd0);
        tick();
        cancel = 1'b0; data_ok = 1'b0;
        #1;
        chk("cxd_state", {30'b0, dbg_state}, 32'd0);
        chk("cxd_data",  bus.data_r,         exp_data);
        tick();

        // reset during WAIT
        bus.en = 1'b1; bus.we = 1'b0; bus.size = 2'b10; bus.addr = 32'h0000_4000;
        addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        rst = 1'b0;
        #1;
        exp_data = RST_VAL;
        chk("rstw_state", {30'b0, dbg_state}, 32'd0);
        chk("rstw_req",   {31'b0, req},       32'd0);
        chk("rstw_data",  bus.data_r,         RST_VAL);
        tick();
        bus.en = 1'b0;
        rst = 1'b1;
        tick();

        // back-to-back reads, en held, address changing after each DONE
        for (int i = 0; i < 4; i++)
            do_txn("b2b", 1'b0, 2'b10, 32'h0000_5000 + 32'(i * 4), 32'h0, 0, 1, $urandom);
        idle_cycle("gap4");

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'b01) a[0]   = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            do_txn("rnd", we, sz, a, $urandom, $urandom_range(0, 3), $urandom_range(1, 4), $urandom);
            if ($urandom_range(0, 1) == 1) idle_cycle("rnd_gap");
        end
        idle_cycle("end");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
